mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Converts the latched load/store control (memread, memwrite, byte, signext, address, store data) into a handshaked request on a multi-cycle data-memory bus.
- Drives stall back to the pipeline register enables (enable = ~stall) until the access completes.
- Returns aligned, extended load data to the MEM/WB path.

Parameters:
TIMEOUT, 16, cycles in REQ without bus_ack before the access is aborted with bus_err
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
memread  in  1  EX/MEM load control
memwrite  in  1  EX/MEM store control; memread and memwrite both high is treated as store
byte_in  in  1  1 = byte access, 0 = word access
signext_in  in  1  byte load: 1 = sign-extend, 0 = zero-extend
addr  in  32  EX/MEM ALU result, effective address
wdata  in  32  EX/MEM B operand, store data
bus_req  out  1  request valid
bus_we  out  1  1 = write
bus_addr  out  32  word address, {addr[31:2],2'b00}
bus_wdata  out  32  lane-placed store data
bus_be  out  4  byte enables
bus_ack  in  1  one-cycle completion from memory
bus_rdata  in  32  read word, valid with bus_ack
load_data  out  32  extended load result
stall  out  1  combinational; hold the EX/MEM register and upstream stages
align_err  out  1  one-cycle pulse, misaligned word access
bus_err  out  1  one-cycle pulse, timeout

Behaviour:
- States: IDLE, REQ, DONE.
- Reset: state=IDLE, counter=0, load_data=0, align_err=0, bus_err=0. Bus outputs are all 0 in IDLE.
- Reset mid-REQ: abort immediately. bus_req=0 on the next cycle; any later bus_ack is ignored.
- op = memread|memwrite.
- stall = (IDLE & op & ~misalign) | REQ. stall is 0 in DONE.
- misalign = op & ~byte_in & (addr[1:0]!=0).
- IDLE transitions:
  - op & misalign: pulse align_err, no bus access, stay IDLE, stall=0 (instruction retires; the exception path handles it).
  - op & ~misalign: go to REQ and capture the request into registers. Store wins over load.
- REQ: bus_req=1. bus_we, bus_addr, bus_wdata and bus_be are held stable from the captured values until ack. The counter increments each cycle.
  - bus_ack: if load, register load_data from bus_rdata; go to DONE.
  - No ack, counter==TIMEOUT-1: pulse bus_err; if load, load_data=0; go to DONE.
  - bus_ack in the same cycle as the timeout: ack wins, no bus_err.
- DONE: one cycle, stall=0, so the pipeline advances at this edge. Always return to IDLE; inputs in DONE are the old instruction and never restart an access. Counter clears.
- Access latency: single bus cycle with ack in the first REQ cycle means IDLE→REQ→DONE; stall is high for 2 cycles.
- Byte store:
  - bus_be = 4'b0001 << addr[1:0].
  - bus_wdata = {4{wdata[7:0]}}.
- Word store: bus_be=4'hF, bus_wdata=wdata.
- Loads: bus_be=4'hF, bus_we=0.
- Byte load: b = bus_rdata[8*addr[1:0] +: 8], little-endian lanes. load_data = signext ? {{24{b[7]}},b} : {24'b0,b}.
- Word load: load_data = bus_rdata.
- load_data holds its value until the next load completes. Stores never modify it.
- bus_ack outside REQ is ignored.

Test Plan:
- Word load, addr=0x100, ack after 3 REQ cycles with rdata=0xDEADBEEF:
  - bus_addr=0x100, be=F, we=0, stall high for 4 cycles.
  - load_data=0xDEADBEEF in DONE.
- Byte load with sign-extend, addr=0x103, rdata=0x80FF_1234, immediate ack:
  - load_data=0xFFFFFF80.
  - Same access with signext=0: load_data=0x00000080.
- Byte store, addr=0x202, wdata=0x000000A5:
  - bus_addr=0x200, be=0100, bus_wdata=0xA5A5A5A5, we=1.
  - load_data unchanged.
- Word load, addr=0x102:
  - align_err pulses one cycle, bus_req never asserts, stall=0.
- No ack, TIMEOUT=16:
  - bus_req high exactly 16 cycles, bus_err pulses, load_data=0, DONE follows.
  - Repeat with ack on cycle 16: no bus_err.
- rst asserted during REQ cycle 2: next cycle state=IDLE, bus_req=0, stall=0, load_data=0. A late ack is ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage memory access unit: turns EX/MEM load/store control into a
// handshaked multi-cycle data-bus request, stalls the pipeline until the
// access completes, and returns aligned, extended load data.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memread,
   input  logic        memwrite,
   input  logic        byte_in,
   input  logic        signext_in,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic [31:0] load_data,
   output logic        stall,
   output logic        align_err,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             cap_load;
   logic             cap_byte;
   logic             cap_sext;
   logic [1:0]       cap_lane;

   logic             op;
   logic             misalign;
   logic             timeout_hit;
   logic [7:0]       rd_byte;
   logic [31:0]      load_ext;

   assign op          = memread | memwrite;
   assign misalign    = op & ~byte_in & (addr[1:0] != 2'b00);
   assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

   // Hold the pipeline while a legal access is being issued or is in flight
   assign stall = ((state == IDLE) & op & ~misalign) | (state == REQ);

   // Select the addressed byte lane and extend it for the writeback path
   always_comb begin
      rd_byte = bus_rdata[7:0];
      case (cap_lane)
         2'd1:    rd_byte = bus_rdata[15:8];
         2'd2:    rd_byte = bus_rdata[23:16];
         2'd3:    rd_byte = bus_rdata[31:24];
         default: rd_byte = bus_rdata[7:0];
      endcase
      if (cap_byte)
         load_ext = cap_sext ? {{24{rd_byte[7]}}, rd_byte} : {24'b0, rd_byte};
      else
         load_ext = bus_rdata;
   end

   // Access FSM with registered bus outputs, load result and error pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cap_load  <= 1'b0;
         cap_byte  <= 1'b0;
         cap_sext  <= 1'b0;
         cap_lane  <= 2'b00;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_be    <= '0;
         load_data <= '0;
         align_err <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         align_err <= 1'b0;
         bus_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (op) begin
                  if (misalign) begin
                     align_err <= 1'b1;
                  end else begin
                     state     <= REQ;
                     cnt       <= '0;
                     cap_load  <= ~memwrite;
                     cap_byte  <= byte_in;
                     cap_sext  <= signext_in;
                     cap_lane  <= addr[1:0];
                     bus_req   <= 1'b1;
                     bus_we    <= memwrite;
                     bus_addr  <= {addr[31:2], 2'b00};
                     if (memwrite && byte_in) begin
                        bus_be    <= 4'b0001 << addr[1:0];
                        bus_wdata <= {4{wdata[7:0]}};
                     end else if (memwrite) begin
                        bus_be    <= 4'hF;
                        bus_wdata <= wdata;
                     end else begin
                        bus_be    <= 4'hF;
                        bus_wdata <= '0;
                     end
                  end
               end
            end
            REQ: begin
               cnt <= cnt + CNT_W'(1);
               if (bus_ack || timeout_hit) begin
                  state     <= DONE;
                  bus_req   <= 1'b0;
                  bus_we    <= 1'b0;
                  bus_addr  <= '0;
                  bus_wdata <= '0;
                  bus_be    <= '0;
                  if (bus_ack) begin
                     if (cap_load) load_data <= load_ext;
                  end else begin
                     bus_err <= 1'b1;
                     if (cap_load) load_data <= '0;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               cnt   <= '0;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: table of load/store transactions
// plus hand-written misalign, timeout and reset-abort sequences.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        memread, memwrite, byte_in, signext_in;
   logic [31:0] addr, wdata;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic [31:0] load_data;
   logic        stall, align_err, bus_err;

   int checks   = 0;
   int failures = 0;
   int cur      = -1;

   mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .memread(memread), .memwrite(memwrite), .byte_in(byte_in), .signext_in(signext_in),
      .addr(addr), .wdata(wdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .load_data(load_data), .stall(stall), .align_err(align_err), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd, wr, bt, sx;
      logic [31:0] addr, wdata;
      int          delay;
      logic [31:0] rdata;
      logic [31:0] e_baddr, e_wdata;
      logic [3:0]  e_be;
      logic        e_we;
      logic [31:0] e_load;
   } vec_t;

   vec_t v[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d actual=%h expected=%h", name, cur, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t t);
      int scount;
      memread = t.rd; memwrite = t.wr; byte_in = t.bt; signext_in = t.sx;
      addr = t.addr; wdata = t.wdata;
      #1;
      chk("stall_idle", 32'(stall), 32'd1);
      scount = stall ? 1 : 0;
      for (int k = 1; k <= t.delay; k++) begin
         tick();
         addr  = ~t.addr;
         wdata = ~t.wdata;
         if (k == t.delay) begin
            bus_ack = 1'b1; bus_rdata = t.rdata;
         end else begin
            bus_rdata = 32'h5A5A_5A5A;
         end
         #1;
         chk("bus_req", 32'(bus_req), 32'd1);
         chk("bus_we", 32'(bus_we), 32'(t.e_we));
         chk("bus_addr", bus_addr, t.e_baddr);
         chk("bus_be", 32'(bus_be), 32'(t.e_be));
         if (t.e_we) chk("bus_wdata", bus_wdata, t.e_wdata);
         if (stall) scount++;
      end
      tick();
      bus_ack = 1'b0; addr = t.addr; wdata = t.wdata;
      #1;
      chk("done_req", 32'(bus_req), 32'd0);
      chk("done_stall", 32'(stall), 32'd0);
      chk("load_data", load_data, t.e_load);
      chk("done_bus_err", 32'(bus_err), 32'd0);
      memread = 1'b0; memwrite = 1'b0;
      tick();
      chk("idle_req", 32'(bus_req), 32'd0);
      chk("idle_stall", 32'(stall), 32'd0);
      chk("stall_cycles", 32'(scount), 32'(t.delay + 1));
   endtask

   initial begin
      int n;
      //       rd    wr    bt    sx    addr          wdata         dly rdata         e_baddr       e_wdata       e_be     we    e_load
      v[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        3, 32'hDEAD_BEEF, 32'h0000_0100, 32'h0,        4'hF,    1'b0, 32'hDEAD_BEEF};
      v[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0103, 32'h0,        1, 32'h80FF_1234, 32'h0000_0100, 32'h0,        4'hF,    1'b0, 32'hFFFF_FF80};
      v[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0103, 32'h0,        1, 32'h80FF_1234, 32'h0000_0100, 32'h0,        4'hF,    1'b0, 32'h0000_0080};
      v[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0202, 32'h0000_00A5, 1, 32'h0,        32'h0000_0200, 32'hA5A5_A5A5, 4'b0100, 1'b1, 32'h0000_0080};
      v[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0101, 32'h0,        2, 32'h1234_5678, 32'h0000_0100, 32'h0,        4'hF,    1'b0, 32'h0000_0056};
      v[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 1, 32'hFFFF_FFFF, 32'h0000_0300, 32'hCAFE_F00D, 4'hF,    1'b1, 32'h0000_0056};
      v[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0,        2, 32'h0000_00FE, 32'h0000_0400, 32'h0,        4'hF,    1'b0, 32'hFFFF_FFFE};
      v[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0006, 32'h0,        1, 32'h00AB_0000, 32'h0000_0004, 32'h0,        4'hF,    1'b0, 32'h0000_00AB};
      v[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0013, 32'h1234_567F, 4, 32'h0,        32'h0000_0010, 32'h7F7F_7F7F, 4'b1000, 1'b1, 32'h0000_00AB};
      v[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0011, 32'h0000_0033, 1, 32'h0,        32'h0000_0010, 32'h3333_3333, 4'b0010, 1'b1, 32'h0000_00AB};

      rst = 1'b1; memread = 1'b0; memwrite = 1'b0; byte_in = 1'b0; signext_in = 1'b0;
      addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      chk("rst_req", 32'(bus_req), 32'd0);
      chk("rst_be", 32'(bus_be), 32'd0);
      chk("rst_load", load_data, 32'd0);
      chk("rst_align", 32'(align_err), 32'd0);
      chk("rst_buserr", 32'(bus_err), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      tick();

      for (int i = 0; i < 10; i++) begin
         cur = i;
         run_vec(v[i]);
      end

      // Misaligned word load: align_err pulse, no bus activity, no stall
      cur = 100;
      memread = 1'b1; byte_in = 1'b0; addr = 32'h0000_0102;
      #1;
      chk("mis_stall", 32'(stall), 32'd0);
      tick();
      chk("mis_align_err", 32'(align_err), 32'd1);
      chk("mis_req", 32'(bus_req), 32'd0);
      memread = 1'b0;
      tick();
      chk("mis_pulse_end", 32'(align_err), 32'd0);
      chk("mis_req2", 32'(bus_req), 32'd0);
      chk("mis_load_kept", load_data, 32'h0000_00AB);

      // No ack: 16 REQ cycles then bus_err, load_data cleared
      cur = 101;
      memread = 1'b1; byte_in = 1'b0; addr = 32'h0000_0500;
      tick();
      n = 0;
      while (bus_req && n < 40) begin
         n++;
         tick();
      end
      chk("to_req_cycles", 32'(n), 32'd16);
      chk("to_bus_err", 32'(bus_err), 32'd1);
      chk("to_load", load_data, 32'd0);
      chk("to_stall", 32'(stall), 32'd0);
      memread = 1'b0;
      tick();
      chk("to_pulse_end", 32'(bus_err), 32'd0);

      // Ack in the timeout cycle wins
      cur = 102;
      memread = 1'b1; addr = 32'h0000_0600;
      tick();
      for (int k = 1; k < 16; k++) begin
         chk("ta_req", 32'(bus_req), 32'd1);
         tick();
      end
      chk("ta_req16", 32'(bus_req), 32'd1);
      bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
      tick();
      bus_ack = 1'b0;
      chk("ta_bus_err", 32'(bus_err), 32'd0);
      chk("ta_load", load_data, 32'h1122_3344);
      chk("ta_req_off", 32'(bus_req), 32'd0);
      memread = 1'b0;
      tick();

      // Reset in REQ cycle 2 aborts; later ack ignored
      cur = 103;
      memread = 1'b1; addr = 32'h0000_0700;
      tick();
      tick();
      chk("ra_req2", 32'(bus_req), 32'd1);
      rst = 1'b1; memread = 1'b0;
      tick();
      chk("ra_req", 32'(bus_req), 32'd0);
      chk("ra_stall", 32'(stall), 32'd0);
      chk("ra_load", load_data, 32'd0);
      rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      tick();
      bus_ack = 1'b0;
      chk("ra_late_req", 32'(bus_req), 32'd0);
      chk("ra_late_load", load_data, 32'd0);
      chk("ra_late_err", 32'(bus_err), 32'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
